rv_imm_gen: RTL and testbench

- Immediate generator for the decode stage of the 5-stage RV32I pipeline.
- Extracts and sign-extends the 32-bit immediate from the fetched instruction, selecting the format by the separately supplied 7-bit opcode.
- Output is registered: one pipeline register feeding the ID/EX boundary.

---
 rtl/rv_imm_gen.sv | 116 +++++++++++
 tb/tb_rv_imm_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rv_imm_gen.sv
// RV32I decode-stage immediate generator with one output register toward ID/EX.
// Optional macro IMM_GEN_ILLEGAL_EN adds a registered illegal_opcode flag.
module rv_imm_gen #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] instruction,
  input  logic [6:0]      opcode,
  output logic [XLEN-1:0] imm_out,
  output logic            out_valid,
  output logic [2:0]      imm_type
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            illegal_opcode
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [2:0] TYPE_I   = 3'd0;
  localparam logic [2:0] TYPE_S   = 3'd1;
  localparam logic [2:0] TYPE_B   = 3'd2;
  localparam logic [2:0] TYPE_U   = 3'd3;
  localparam logic [2:0] TYPE_J   = 3'd4;
  localparam logic [2:0] TYPE_DEF = 3'd5;

  logic [XLEN-1:0] imm_s;
  logic [2:0]      type_s;
  logic            illegal_s;
  logic [XLEN-1:0] imm_r;
  logic            valid_r;
  logic [2:0]      type_r;
  logic            illegal_r;

  // The format is chosen by the opcode port, so the opcode bits of the word are never read.
  logic            unused_opc_bits_s;
  assign unused_opc_bits_s = ^instruction[6:0];

  // Combinational format select and immediate assembly.
  always_comb begin
    imm_s     = {{20{instruction[31]}}, instruction[31:20]};
    type_s    = TYPE_DEF;
    illegal_s = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        imm_s  = {{20{instruction[31]}}, instruction[31:20]};
        type_s = TYPE_I;
      end
      OP_STORE: begin
        imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        type_s = TYPE_S;
      end
      OP_BRANCH: begin
        imm_s  = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
        type_s = TYPE_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm_s  = {instruction[31:12], 12'h000};
        type_s = TYPE_U;
      end
      OP_JAL: begin
        imm_s  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
        type_s = TYPE_J;
      end
      default: begin
        // Unknown opcodes still get an I-type immediate so downstream sees a defined value.
        imm_s     = {{20{instruction[31]}}, instruction[31:20]};
        type_s    = TYPE_DEF;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Output register: reset dominates, otherwise capture on valid and hold data when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_r     <= 32'h0000_0000;
      valid_r   <= 1'b0;
      type_r    <= TYPE_I;
      illegal_r <= 1'b0;
    end else if (in_valid) begin
      imm_r     <= imm_s;
      valid_r   <= 1'b1;
      type_r    <= type_s;
      illegal_r <= illegal_s;
    end else begin
      imm_r     <= imm_r;
      valid_r   <= 1'b0;
      type_r    <= type_r;
      illegal_r <= illegal_r;
    end
  end

  assign imm_out   = imm_r;
  assign out_valid = valid_r;
  assign imm_type  = type_r;

`ifdef IMM_GEN_ILLEGAL_EN
  assign illegal_opcode = illegal_r;
`else
  logic unused_illegal_s;
  assign unused_illegal_s = illegal_r;
`endif

endmodule

// File: tb/tb_rv_imm_gen.sv
// Self-checking bench for rv_imm_gen: vector table plus scoreboard queue,
// with hand sequences for reset, hold and reset/valid collision.
module tb_rv_imm_gen;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [31:0] imm_out;
  logic        out_valid;
  logic [2:0]  imm_type;
`ifdef IMM_GEN_ILLEGAL_EN
  logic        illegal_opcode;
`endif

  rv_imm_gen #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .instruction (instruction),
    .opcode      (opcode),
    .imm_out     (imm_out),
    .out_valid   (out_valid),
    .imm_type    (imm_type)
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    .illegal_opcode (illegal_opcode)
`endif
  );

  typedef struct {
    logic        r;
    logic        v;
    logic [6:0]  op;
    logic [31:0] ins;
    logic [31:0] imm;
    logic [2:0]  ty;
    logic        ov;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  ty;
    logic        ov;
    logic        ill;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  // Bench-side held output state, used only for random rows.
  logic [31:0] m_imm = 32'h0;
  logic [2:0]  m_ty  = 3'd0;
  logic        m_ill = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference immediate built with arithmetic shifts and masks.
  function automatic void model(input logic [6:0] op, input logic [31:0] ins,
                                output logic [31:0] imm, output logic [2:0] ty,
                                output logic ill);
    logic signed [31:0] s;
    s   = $signed(ins);
    ill = 1'b0;
    if (op == 7'h03 || op == 7'h13 || op == 7'h67) begin
      imm = 32'(s >>> 20); ty = 3'd0;
    end else if (op == 7'h23) begin
      imm = (32'(s >>> 25) << 5) | ((ins >> 7) & 32'h1F); ty = 3'd1;
    end else if (op == 7'h63) begin
      imm = (32'(s >>> 31) << 12) | (((ins >> 7) & 32'h1) << 11) |
            (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      ty = 3'd2;
    end else if (op == 7'h37 || op == 7'h17) begin
      imm = ins & 32'hFFFF_F000; ty = 3'd3;
    end else if (op == 7'h6F) begin
      imm = (32'(s >>> 31) << 20) | (ins & 32'h000F_F000) |
            (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      ty = 3'd4;
    end else begin
      imm = 32'(s >>> 20); ty = 3'd5; ill = 1'b1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, and check after the edge.
  task automatic step(input vec_t t, input string name);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst         = t.r;
    in_valid    = t.v;
    opcode      = t.op;
    instruction = t.ins;
    e.imm = t.imm; e.ty = t.ty; e.ov = t.ov; e.ill = t.ill;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      g = sb_q.pop_front();
      check({name, ".imm"},   imm_out,          g.imm);
      check({name, ".type"},  {29'd0, imm_type}, {29'd0, g.ty});
      check({name, ".valid"}, {31'd0, out_valid}, {31'd0, g.ov});
`ifdef IMM_GEN_ILLEGAL_EN
      check({name, ".ill"},   {31'd0, illegal_opcode}, {31'd0, g.ill});
`endif
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [6:0] op,
                              input logic [31:0] ins, input logic [31:0] imm,
                              input logic [2:0] ty, input logic ov, input logic ill);
    vec_t t;
    t.r = r; t.v = v; t.op = op; t.ins = ins;
    t.imm = imm; t.ty = ty; t.ov = ov; t.ill = ill;
    return t;
  endfunction

  initial begin
    logic [6:0]  ops [0:8];
    logic [31:0] ri;
    logic [6:0]  ro;
    logic [31:0] mi;
    logic [2:0]  mt;
    logic        ml;
    rst = 1'b1; in_valid = 1'b1; opcode = 7'h13; instruction = 32'hDEAD_BEEF;

    // Reset with live inputs, then idle after release.
    step(mk(1'b1, 1'b1, 7'h13, 32'hDEAD_BEEF, 32'h0, 3'd0, 1'b0, 1'b0), "rst0");
    step(mk(1'b1, 1'b1, 7'h6F, 32'hFFFF_FFFF, 32'h0, 3'd0, 1'b0, 1'b0), "rst1");
    step(mk(1'b0, 1'b0, 7'h23, 32'h1234_5678, 32'h0, 3'd0, 1'b0, 1'b0), "idle");

    // Directed table of format cases.
    tbl.push_back(mk(1'b0, 1'b1, 7'd35,  32'h0F20_0700, 32'h0000_00EE, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'd1,   32'hFF20_0000, 32'hFFFF_FFF2, 3'd5, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 7'd99,  32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'd111, 32'h0080_006F, 32'h0000_0008, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'd55,  32'h1234_5037, 32'h1234_5000, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 7'd19,  32'hFFF0_0013, 32'h1234_5000, 3'd3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'h17,  32'hFFFF_F017, 32'hFFFF_F000, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'h67,  32'h7FF0_0067, 32'h0000_07FF, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'h13,  32'h4050_5093, 32'h0000_0405, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'h6F,  32'h8000_006F, 32'hFFF0_0000, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'h63,  32'h8000_0063, 32'hFFFF_F000, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 7'h7F,  32'h0010_0000, 32'h0000_0001, 3'd5, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 7'h03,  32'hFFFF_FFFF, 32'h0000_0001, 3'd5, 1'b0, 1'b1));
    m_imm = 32'h0000_0001; m_ty = 3'd5; m_ill = 1'b1;

    // Random rows, expectations from the shift/mask model.
    ops[0] = 7'h03; ops[1] = 7'h13; ops[2] = 7'h67; ops[3] = 7'h23; ops[4] = 7'h63;
    ops[5] = 7'h37; ops[6] = 7'h17; ops[7] = 7'h6F; ops[8] = 7'h00;
    for (int i = 0; i < 24; i++) begin
      ri = $urandom;
      ro = (i % 5 == 4) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      if (i % 7 == 6) begin
        tbl.push_back(mk(1'b0, 1'b0, ro, ri, m_imm, m_ty, 1'b0, m_ill));
      end else begin
        model(ro, ri, mi, mt, ml);
        m_imm = mi; m_ty = mt; m_ill = ml;
        tbl.push_back(mk(1'b0, 1'b1, ro, ri, mi, mt, 1'b1, ml));
      end
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset collides with a valid I-type; the following edge captures it.
    step(mk(1'b1, 1'b1, 7'd19, 32'h8000_0013, 32'h0000_0000, 3'd0, 1'b0, 1'b0), "coll_rst");
    step(mk(1'b0, 1'b1, 7'd19, 32'h8000_0013, 32'hFFFF_F800, 3'd0, 1'b1, 1'b0), "coll_next");
    step(mk(1'b0, 1'b0, 7'h23, 32'h0000_0000, 32'hFFFF_F800, 3'd0, 1'b0, 1'b0), "coll_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
